// File: rtl/freq_scan_scheduler_pkg.sv
// Shared types and defaults for the frequency scan scheduler.
// State encoding covers the optional IDLE state used only with channel masking.
package freq_scan_scheduler_pkg;

  localparam int FSCAN_BITS           = 12;
  localparam int FSCAN_DEFAULT_PERIOD = 1200;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DWELL   = 3'd3,
    ST_ADVANCE = 3'd4
  } fscan_state_t;

endpackage

// File: rtl/freq_scan_scheduler_if.sv
// Config write port and frequency_counter drive bundle of the scan scheduler.
// master = scheduler side, slave = register host / counter side.
interface freq_scan_scheduler_if
  import freq_scan_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int BITS = FSCAN_BITS
);
  localparam int CW = $clog2(N_CH);

  logic            cfg_we;
  logic [CW-1:0]   cfg_addr;
  logic [BITS-1:0] cfg_data;

  logic            ctr_reset;
  logic            ctr_signal;
  logic [BITS-1:0] ctr_period;
  logic            ctr_period_load;
  logic [CW-1:0]   chan_sel;
  logic            scan_wrap;

  modport master (
    input  cfg_we, cfg_addr, cfg_data,
    output ctr_reset, ctr_signal, ctr_period, ctr_period_load, chan_sel, scan_wrap
  );

  modport slave (
    output cfg_we, cfg_addr, cfg_data,
    input  ctr_reset, ctr_signal, ctr_period, ctr_period_load, chan_sel, scan_wrap
  );

endinterface

// File: rtl/freq_scan_scheduler_rr_next_chan.sv
// Combinational round-robin pick: next set mask bit strictly after cur (cur itself last),
// plus wrap flag (pick <= cur), any-bit-set flag and lowest set bit.
module freq_scan_scheduler_rr_next_chan #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         mask,
  input  logic [$clog2(N_CH)-1:0] cur,
  output logic [$clog2(N_CH)-1:0] nxt_ch,
  output logic                    wrap,
  output logic                    any,
  output logic [$clog2(N_CH)-1:0] lowest
);
  localparam int CW = $clog2(N_CH);

  int   k;
  logic found;

  always_comb begin
    nxt_ch = cur;
    found  = 1'b0;
    k      = 0;
    for (int i = 1; i <= N_CH; i++) begin
      k = int'(cur) + i;
      if (k >= N_CH) k = k - N_CH;
      if (!found && mask[k[CW-1:0]]) begin
        nxt_ch = k[CW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest = CW'(i);
    end
  end

  assign any  = |mask;
  assign wrap = found && (nxt_ch <= cur);

endmodule

// File: rtl/freq_scan_scheduler.sv
// Round-robin scheduler time-sharing one frequency_counter over N_CH inputs; 3-cycle switch latency.
// FSCAN_MASK_EN adds chan_mask channel enables and an IDLE state when no channel is enabled.
module freq_scan_scheduler
  import freq_scan_scheduler_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int BITS           = FSCAN_BITS,
  parameter int DEFAULT_PERIOD = FSCAN_DEFAULT_PERIOD,
  parameter int SLACK          = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       sig_in,
  input  logic                  hold,
`ifdef FSCAN_MASK_EN
  input  logic [N_CH-1:0]       chan_mask,
`endif
  freq_scan_scheduler_if.master bus
);
  localparam int CW = $clog2(N_CH);
  localparam int DW = BITS + 2;

  fscan_state_t    state, state_nx;
  logic [CW-1:0]   ch, ch_nx, next_ch;
  logic            next_wrap;
  logic [DW-1:0]   dwell_cnt, dwell_nx, target;
  logic [BITS-1:0] period_lat, lat_nx;
  logic [BITS-1:0] period_reg [N_CH];
  logic            o_rst, o_sig, o_load, o_wrap;
  logic [BITS-1:0] o_period;

`ifdef FSCAN_MASK_EN
  logic            mask_any;
  logic [CW-1:0]   mask_low;

  freq_scan_scheduler_rr_next_chan #(.N_CH(N_CH)) u_rr (
    .mask   (chan_mask),
    .cur    (ch),
    .nxt_ch (next_ch),
    .wrap   (next_wrap),
    .any    (mask_any),
    .lowest (mask_low)
  );
`else
  assign next_ch   = (int'(ch) == N_CH - 1) ? '0 : ch + CW'(1);
  assign next_wrap = (next_ch <= ch);
`endif

  // Two full counter windows plus margin guarantee one complete measure/display cycle.
  assign target = DW'({period_lat, 1'b0}) + DW'(SLACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) period_reg[i] <= BITS'(DEFAULT_PERIOD);
    end else if (bus.cfg_we && (int'(bus.cfg_addr) < N_CH)) begin
      period_reg[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FLUSH;
      ch         <= '0;
      dwell_cnt  <= '0;
      period_lat <= BITS'(DEFAULT_PERIOD);
    end else begin
      state      <= state_nx;
      ch         <= ch_nx;
      dwell_cnt  <= dwell_nx;
      period_lat <= lat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    dwell_nx = dwell_cnt;
    lat_nx   = period_lat;
    o_rst    = 1'b0;
    o_sig    = 1'b0;
    o_load   = 1'b0;
    o_wrap   = 1'b0;
    o_period = period_lat;
    unique case (state)
      ST_IDLE: begin
        o_rst = 1'b1;
`ifdef FSCAN_MASK_EN
        if (mask_any) begin
          ch_nx    = mask_low;
          state_nx = ST_FLUSH;
        end
`endif
      end
      ST_FLUSH: begin
        o_rst    = 1'b1;
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        lat_nx   = period_reg[ch];
        o_load   = 1'b1;
        o_period = period_reg[ch];
        state_nx = ST_DWELL;
      end
      ST_DWELL: begin
        o_sig = sig_in[ch];
        if (dwell_cnt == target - DW'(1)) begin
          // hold keeps the counter running on this channel for another full dwell
          if (hold) dwell_nx = '0;
          else      state_nx = ST_ADVANCE;
        end else begin
          dwell_nx = dwell_cnt + DW'(1);
        end
      end
      ST_ADVANCE: begin
        dwell_nx = '0;
`ifdef FSCAN_MASK_EN
        if (mask_any) begin
          ch_nx    = next_ch;
          o_wrap   = next_wrap;
          state_nx = ST_FLUSH;
        end else begin
          state_nx = ST_IDLE;
        end
`else
        ch_nx    = next_ch;
        o_wrap   = next_wrap;
        state_nx = ST_FLUSH;
`endif
      end
      default: state_nx = ST_FLUSH;
    endcase
  end

  assign bus.ctr_reset       = o_rst;
  assign bus.ctr_signal      = o_sig;
  assign bus.ctr_period      = o_period;
  assign bus.ctr_period_load = o_load;
  assign bus.chan_sel        = ch;
  assign bus.scan_wrap       = o_wrap;

endmodule
